// File: rtl/reg_access_bridge.sv
// -----------------------------------------------------------------------------
// reg_access_bridge
//
// Upstream master-side stage for the controlling register block. It accepts
// one register request at a time over a valid/ready handshake, drives the
// register strobe bus, samples read_data and returns a response over a second
// valid/ready handshake. Only one transaction is ever outstanding.
//
// Optional feature macro: REG_BRIDGE_RANGE_CHECK_EN
//   Defined     : requests outside [ADDR_MIN, ADDR_MAX] issue no strobe and
//                 are answered one cycle after acceptance with rsp_err=1.
//   Not defined : every request is forwarded and rsp_err stays 0.
//
// Ports
//   clock, reset        clock; asynchronous active-low reset
//   req_valid/req_ready request handshake
//   req_write           1 = write, 0 = read
//   req_addr/req_wdata  request address / write data
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata/rsp_err   read data (0 for writes) / error flag
//   address             register bus address (held until the next acceptance)
//   write_enable        one-cycle register write strobe
//   write_data          register write data (held until the next acceptance)
//   read_enable         register read strobe, high for RD_LAT+1 cycles
//   read_data           register read data, captured at the end of the read
// -----------------------------------------------------------------------------
module reg_access_bridge #(
    parameter int                ADDR_W   = 33,
    parameter int                WDATA_W  = 33,
    parameter int                RDATA_W  = 21,
    parameter int                RD_LAT   = 1,
    parameter logic [ADDR_W-1:0] ADDR_MIN = '0,
    parameter logic [ADDR_W-1:0] ADDR_MAX = 'hFF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [WDATA_W-1:0] req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [RDATA_W-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic [ADDR_W-1:0]  address,
    output logic               write_enable,
    output logic [WDATA_W-1:0] write_data,
    output logic               read_enable,
    input  logic [RDATA_W-1:0] read_data
);

    // Refuse to build with a latency the 4-bit counter cannot hold or with an
    // empty legal address window.
    if (RD_LAT < 0 || RD_LAT > 15 || ADDR_MIN > ADDR_MAX) begin : g_bad_config
        $error("reg_access_bridge: RD_LAT must be 0..15 and ADDR_MIN <= ADDR_MAX");
    end

    localparam logic [3:0] RD_LAT_CNT = 4'(RD_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t     state_reg;
    logic [3:0] lat_cnt_reg;   // remaining extra read cycles
    logic       addr_ok;       // request address may be forwarded

`ifdef REG_BRIDGE_RANGE_CHECK_EN
    logic addr_low_ok;

    // A zero lower bound is always satisfied; skip the compare so it does not
    // degenerate into an always-true unsigned comparison.
    if (ADDR_MIN == '0) begin : g_low_free
        assign addr_low_ok = 1'b1;
    end else begin : g_low_cmp
        assign addr_low_ok = (req_addr >= ADDR_MIN);
    end

    assign addr_ok = addr_low_ok && (req_addr <= ADDR_MAX);
`else
    assign addr_ok = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            lat_cnt_reg  <= '0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            address      <= '0;
            write_enable <= 1'b0;
            write_data   <= '0;
            read_enable  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // req_ready comes out of reset low and rises here on the
                    // first edge; afterwards it is already high in IDLE.
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        address    <= req_addr;
                        write_data <= req_wdata;
                        if (!addr_ok) begin
                            // Out-of-window request: answer immediately, no strobe.
                            state_reg <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_write) begin
                            state_reg    <= WR;
                            write_enable <= 1'b1;
                        end else begin
                            state_reg   <= RD;
                            read_enable <= 1'b1;
                            lat_cnt_reg <= RD_LAT_CNT;
                        end
                    end
                end

                WR: begin
                    write_enable <= 1'b0;
                    rsp_valid    <= 1'b1;
                    rsp_rdata    <= '0;
                    rsp_err      <= 1'b0;
                    state_reg    <= RSP;
                end

                RD: begin
                    if (lat_cnt_reg == 4'd0) begin
                        // Last read cycle: sample and drop the strobe together.
                        read_enable <= 1'b0;
                        rsp_rdata   <= read_data;
                        rsp_err     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state_reg   <= RSP;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 4'd1;
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_bridge.sv
// -----------------------------------------------------------------------------
// tb_reg_access_bridge
//
// Self-checking bench for reg_access_bridge. A simple register-block slave
// answers the strobe bus; a transaction-level memory model predicts read data
// and the latency/strobe-count rules predict bus behaviour. Directed cases
// cover the documented scenarios, followed by randomized transactions.
// -----------------------------------------------------------------------------
module tb_reg_access_bridge;

    localparam int AW     = 33;
    localparam int WW     = 33;
    localparam int RW     = 21;
    localparam int RD_LAT = 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [WW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [RW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] address;
    logic          write_enable;
    logic [WW-1:0] write_data;
    logic          read_enable;
    logic [RW-1:0] read_data;

    int total = 0;
    int bad   = 0;
    int txn_no = 0;

    reg_access_bridge #(
        .ADDR_W  (AW),
        .WDATA_W (WW),
        .RDATA_W (RW),
        .RD_LAT  (RD_LAT),
        .ADDR_MIN(33'h0),
        .ADDR_MAX(33'hFF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .address     (address),
        .write_enable(write_enable),
        .write_data  (write_data),
        .read_enable (read_enable),
        .read_data   (read_data)
    );

    always #5 clock = ~clock;

    // Power-on content of a register that has never been written.
    function automatic logic [RW-1:0] init_val(input logic [7:0] idx);
        logic [7:0] k;
        k = idx ^ 8'h55;
        return 21'h0ABCD ^ (21'(k) * 21'h01357);
    endfunction

    // ---------------- register-block slave ----------------
    logic [RW-1:0] slave_mem [256];
    logic [255:0]  slave_written;
    logic          slave_clr = 1'b1;
    logic [7:0]    slave_idx;

    assign slave_idx = address[7:0];
    assign read_data = slave_written[slave_idx] ? slave_mem[slave_idx] : init_val(slave_idx);

    always @(posedge clock) begin
        if (slave_clr) begin
            slave_written <= '0;
        end else if (write_enable) begin
            slave_mem[slave_idx]     <= write_data[RW-1:0];
            slave_written[slave_idx] <= 1'b1;
        end
    end

    // ---------------- transaction-level model ----------------
    logic [RW-1:0] model_mem [256];
    bit            model_wr  [256];

    function automatic logic [RW-1:0] model_read(input logic [7:0] idx);
        return model_wr[idx] ? model_mem[idx] : init_val(idx);
    endfunction

    function automatic bit addr_err(input logic [AW-1:0] a);
`ifdef REG_BRIDGE_RANGE_CHECK_EN
        return a > 33'hFF;
`else
        return (a != a);
`endif
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full request/response exchange with cycle-accurate checks.
    task automatic do_txn(input bit wr, input logic [AW-1:0] a, input logic [WW-1:0] d,
                          input int hold, input bit junk);
        bit            err;
        int            exp_lat;
        int            lat;
        int            we_n;
        int            re_n;
        logic [RW-1:0] exp_rd;
        logic [7:0]    idx;
        idx     = a[7:0];
        err     = addr_err(a);
        exp_lat = err ? 1 : (wr ? 2 : 2 + RD_LAT);
        exp_rd  = (err || wr) ? '0 : model_read(idx);

        @(negedge clock);
        check_val("ready_at_start", 64'(req_ready), 64'(1));
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(posedge clock); #1;           // accept edge T
        req_valid = 1'b0;
        check_val("ready_after_accept", 64'(req_ready), 64'(0));

        lat  = 1;
        we_n = 0;
        re_n = 0;
        while (!rsp_valid && lat < 40) begin
            check_val("strobe_exclusive", 64'(write_enable & read_enable), 64'(0));
            if (write_enable) begin
                we_n++;
                check_val("wr_address", 64'(address), 64'(a));
                check_val("wr_data", 64'(write_data), 64'(d));
            end
            if (read_enable) begin
                re_n++;
                check_val("rd_address", 64'(address), 64'(a));
            end
            @(posedge clock); #1;
            lat++;
        end
        check_val("rsp_latency", 64'(lat), 64'(exp_lat));
        check_val("we_cycles", 64'(we_n), 64'((!err && wr) ? 1 : 0));
        check_val("re_cycles", 64'(re_n), 64'((!err && !wr) ? RD_LAT + 1 : 0));
        check_val("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        check_val("rsp_err", 64'(rsp_err), 64'(err));
        check_val("strobes_in_rsp", 64'({write_enable, read_enable}), 64'(0));

        // Optional stray request while the response is pending.
        if (junk) begin
            req_valid = 1'b1;
            req_write = ~wr;
            req_addr  = a ^ 33'h3;
            req_wdata = ~d;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check_val("hold_valid", 64'(rsp_valid), 64'(1));
            check_val("hold_rdata", 64'(rsp_rdata), 64'(exp_rd));
            check_val("hold_ready", 64'(req_ready), 64'(0));
            check_val("hold_strobes", 64'({write_enable, read_enable}), 64'(0));
            check_val("hold_address", 64'(address), 64'(a));
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;           // response handshake edge
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check_val("rsp_cleared", 64'(rsp_valid), 64'(0));
        check_val("ready_restored", 64'(req_ready), 64'(1));

        if (!err && wr) begin
            model_mem[idx] = d[RW-1:0];
            model_wr[idx]  = 1'b1;
        end
        txn_no++;
        $display("txn %0d %s addr=%0h wdata=%0h rdata=%0h err=%0d lat=%0d hold=%0d",
                 txn_no, wr ? "WR" : "RD", a, d, rsp_rdata, rsp_err, lat, hold);
    endtask

    // Four writes with req_valid and rsp_ready held high.
    task automatic back_to_back();
        logic [AW-1:0] b_addr [4];
        logic [WW-1:0] b_data [4];
        int            acc_cyc [4];
        logic [AW-1:0] we_addrs [$];
        int            k;
        int            cyc;
        int            consec;
        bit            prev_we;
        bit            rdy;
        bit            vld;
        for (int i = 0; i < 4; i++) begin
            b_addr[i] = 33'($urandom_range(255, 0));
            b_data[i] = {1'b0, $urandom};
        end
        rsp_ready = 1'b1;
        req_write = 1'b1;
        req_valid = 1'b1;
        req_addr  = b_addr[0];
        req_wdata = b_data[0];
        k = 0; cyc = 0; consec = 0; prev_we = 1'b0;
        repeat (16) begin
            rdy = req_ready;
            vld = req_valid;
            @(posedge clock); #1;
            cyc++;
            if (rdy && vld) begin
                acc_cyc[k] = cyc;
                k++;
                if (k < 4) begin
                    req_addr  = b_addr[k];
                    req_wdata = b_data[k];
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (write_enable) begin
                we_addrs.push_back(address);
                if (prev_we) consec++;
            end
            prev_we = write_enable;
        end
        rsp_ready = 1'b0;
        check_val("b2b_accepts", 64'(k), 64'(4));
        for (int i = 1; i < k; i++)
            check_val("b2b_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(3));
        check_val("b2b_pulses", 64'(we_addrs.size()), 64'(4));
        check_val("b2b_pulse_width", 64'(consec), 64'(0));
        for (int i = 0; i < 4 && i < we_addrs.size(); i++)
            check_val("b2b_addr_order", 64'(we_addrs[i]), 64'(b_addr[i]));
        for (int i = 0; i < 4; i++) begin
            model_mem[b_addr[i][7:0]] = b_data[i][RW-1:0];
            model_wr[b_addr[i][7:0]]  = 1'b1;
            txn_no++;
            $display("txn %0d WR addr=%0h wdata=%0h (back-to-back)", txn_no, b_addr[i], b_data[i]);
        end
    endtask

    // Reset asserted during the second read cycle.
    task automatic reset_mid_read(input logic [AW-1:0] a);
        bit any_rsp;
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check_val("rst_rd_cycle1", 64'(read_enable), 64'(1));
        @(posedge clock); #1;
        check_val("rst_rd_cycle2", 64'(read_enable), 64'(1));
        reset = 1'b0;
        #1;
        check_val("rst_strobe_drop", 64'(read_enable), 64'(0));
        check_val("rst_rsp_drop", 64'(rsp_valid), 64'(0));
        check_val("rst_ready_low", 64'(req_ready), 64'(0));
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check_val("rst_ready_rise", 64'(req_ready), 64'(1));
        any_rsp = 1'b0;
        repeat (6) begin
            if (rsp_valid || read_enable || write_enable) any_rsp = 1'b1;
            @(posedge clock); #1;
        end
        check_val("rst_no_response", 64'(any_rsp), 64'(0));
        txn_no++;
        $display("txn %0d RD addr=%0h aborted by reset", txn_no, a);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [WW-1:0] d;
        for (int i = 0; i < 256; i++) model_wr[i] = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_val("reset_outputs",
                  64'({req_ready, rsp_valid, rsp_err, write_enable, read_enable}), 64'(0));
        check_val("reset_rdata", 64'(rsp_rdata), 64'(0));
        check_val("reset_address", 64'(address), 64'(0));
        check_val("reset_wdata", 64'(write_data), 64'(0));
        slave_clr = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check_val("ready_first_edge", 64'(req_ready), 64'(1));

        // Directed: write, read of preset value, backpressure with stray request
        do_txn(1'b1, 33'hAA, 33'h1234, 0, 1'b0);
        do_txn(1'b0, 33'h55, 33'h0, 0, 1'b0);
        do_txn(1'b0, 33'hAA, 33'h0, 5, 1'b1);
        do_txn(1'b1, 33'h10, 33'h1_5A5A_5A5A, 0, 1'b0);

        back_to_back();

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
`ifdef REG_BRIDGE_RANGE_CHECK_EN
            if ($urandom_range(7, 0) == 0) a = 33'h100 + 33'($urandom_range(60, 0));
            else                           a = 33'($urandom_range(255, 0));
`else
            a = 33'($urandom_range(255, 0));
`endif
            d = {1'b0, $urandom};
            do_txn(1'($urandom_range(1, 0)), a, d, $urandom_range(3, 0),
                   ($urandom_range(3, 0) == 0));
        end

`ifdef REG_BRIDGE_RANGE_CHECK_EN
        do_txn(1'b0, 33'h100, 33'h0, 0, 1'b0);
        do_txn(1'b1, 33'h1_0000_0000, 33'h7, 1, 1'b0);
`endif

        reset_mid_read(33'h55);
        do_txn(1'b0, 33'hAA, 33'h0, 0, 1'b0);
        do_txn(1'b1, 33'h55, 33'h0_000F_0F0F, 0, 1'b0);
        do_txn(1'b0, 33'h55, 33'h0, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
